// File: rtl/video_raster_tracker_pkg.sv
// Shared constants and types for the raster tracker: fvht bit positions,
// lock state encoding and default 1080p geometry.
package video_raster_tracker_pkg;

  localparam int FVHT_F = 3;
  localparam int FVHT_V = 2;
  localparam int FVHT_H = 1;
  localparam int FVHT_T = 0;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_CW       = 12;
  localparam int DEF_LOCK_FRM = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } raster_state_t;

endpackage

// File: rtl/video_raster_tracker_if.sv
// Video in/out bundle of the raster tracker; slave side is the tracker itself.
interface video_raster_tracker_if #(
  parameter int CW = 12
);
  logic          cen_i;
  logic [3:0]    fvht_i;
  logic [19:0]   vdat_i;
  logic          err_clr_i;
  logic [3:0]    fvht_o;
  logic [19:0]   vdat_o;
  logic [CW-1:0] hcount_o;
  logic [CW-1:0] vcount_o;
  logic          active_o;
  logic          chroma_cr_o;
  logic          sol_o;
  logic          sof_o;
  logic          locked_o;
  logic          err_o;

  modport master (
    output cen_i, fvht_i, vdat_i, err_clr_i,
    input  fvht_o, vdat_o, hcount_o, vcount_o, active_o, chroma_cr_o,
           sol_o, sof_o, locked_o, err_o
  );

  modport slave (
    input  cen_i, fvht_i, vdat_i, err_clr_i,
    output fvht_o, vdat_o, hcount_o, vcount_o, active_o, chroma_cr_o,
           sol_o, sof_o, locked_o, err_o
  );
endinterface

// File: rtl/video_raster_tracker_fvht_edge_detect.sv
// Previous-sample registers for v/h blanking flags and their rise/fall strobes.
module video_raster_tracker_fvht_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cen_i,
  input  logic v_i,
  input  logic h_i,
  output logic v_rise_o,
  output logic v_fall_o,
  output logic h_rise_o,
  output logic h_fall_o
);
  logic v_prev, h_prev;

  // Clearing to 0 means a reset taken mid-line never fakes a falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_prev <= 1'b0;
      h_prev <= 1'b0;
    end else if (cen_i) begin
      v_prev <= v_i;
      h_prev <= h_i;
    end
  end

  assign v_rise_o = ~v_prev & v_i;
  assign v_fall_o = v_prev & ~v_i;
  assign h_rise_o = ~h_prev & h_i;
  assign h_fall_o = h_prev & ~h_i;
endmodule

// File: rtl/video_raster_tracker.sv
// Decodes fvht timing into registered raster coordinates aligned with a 1-clk
// delayed copy of the video, and checks line/frame geometry for lock and errors.
module video_raster_tracker
  import video_raster_tracker_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int CW       = DEF_CW,
  parameter int LOCK_FRM = DEF_LOCK_FRM
) (
  input logic                   clk_i,
  input logic                   rst_i,
  video_raster_tracker_if.slave vif
);
  localparam int CCW = $clog2(LOCK_FRM + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  logic v_rise, v_fall, h_rise, h_fall;
  logic v_in, h_in;

  assign v_in = vif.fvht_i[FVHT_V];
  assign h_in = vif.fvht_i[FVHT_H];

  video_raster_tracker_fvht_edge_detect u_edge (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cen_i    (vif.cen_i),
    .v_i      (v_in),
    .h_i      (h_in),
    .v_rise_o (v_rise),
    .v_fall_o (v_fall),
    .h_rise_o (h_rise),
    .h_fall_o (h_fall)
  );

  // tracking state
  logic          in_frame_q, in_frame_d;
  logic          first_line_q, first_line_d;
  logic [CW-1:0] line_idx_q, line_idx_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic          frame_err_q, frame_err_d;
  raster_state_t state_q, state_d;
  logic [CCW-1:0] clean_cnt_q, clean_cnt_d;

  // output registers
  logic [3:0]    fvht_q;
  logic [19:0]   vdat_q;
  logic [CW-1:0] hcount_q, vcount_q;
  logic          active_q, sol_q, sof_q, err_q;

  logic          active, sol, line_err, frame_bad, frame_end, geo_err;
  logic [CW-1:0] cur_sample;
  logic [CW:0]   lines_seen;

  always_comb begin
    in_frame_d   = in_frame_q;
    first_line_d = first_line_q;
    line_idx_d   = line_idx_q;
    sample_cnt_d = sample_cnt_q;
    frame_err_d  = frame_err_q;
    cur_sample   = sample_cnt_q;
    line_err     = 1'b0;
    frame_bad    = 1'b0;
    frame_end    = 1'b0;
    sol          = 1'b0;
    lines_seen   = first_line_q ? '0 : {1'b0, line_idx_q} + 1'b1;

    // Geometry checks close out the line/frame that was open before this sample.
    if (h_rise && in_frame_q && !first_line_q && sample_cnt_q != CW'(H_ACTIVE))
      line_err = 1'b1;
    if (v_rise && in_frame_q) begin
      frame_end = 1'b1;
      frame_bad = (lines_seen != (CW+1)'(V_ACTIVE));
    end

    if (v_fall) begin
      in_frame_d   = 1'b1;
      line_idx_d   = '0;
      first_line_d = 1'b1;
      frame_err_d  = 1'b0;
    end
    if (v_rise)
      in_frame_d = 1'b0;
    if (line_err)
      frame_err_d = 1'b1;

    // The v edge is applied first, so a line can open on the same sample.
    if (h_fall && in_frame_d && !v_in) begin
      cur_sample = '0;
      sol        = 1'b1;
      if (first_line_d) first_line_d = 1'b0;
      else              line_idx_d   = sat_inc(line_idx_d);
    end

    active = ~h_in & ~v_in & in_frame_d & ~first_line_d;
    if (active)
      sample_cnt_d = sat_inc(cur_sample);
    sol     = sol & active;
    geo_err = line_err | frame_bad;
  end

  always_comb begin
    state_d     = state_q;
    clean_cnt_d = clean_cnt_q;
    unique case (state_q)
      UNLOCKED: if (v_fall) begin
        state_d     = ACQUIRE;
        clean_cnt_d = '0;
      end
      ACQUIRE: begin
        if (geo_err)
          clean_cnt_d = '0;
        else if (frame_end && !frame_err_q) begin
          if (clean_cnt_q + 1'b1 == CCW'(LOCK_FRM)) begin
            state_d     = LOCKED;
            clean_cnt_d = '0;
          end else begin
            clean_cnt_d = clean_cnt_q + 1'b1;
          end
        end
      end
      LOCKED:  if (geo_err) state_d = UNLOCKED;
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= UNLOCKED;
      clean_cnt_q <= '0;
    end else if (vif.cen_i) begin
      state_q     <= state_d;
      clean_cnt_q <= clean_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_frame_q   <= 1'b0;
      first_line_q <= 1'b0;
      line_idx_q   <= '0;
      sample_cnt_q <= '0;
      frame_err_q  <= 1'b0;
      fvht_q       <= '0;
      vdat_q       <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      active_q     <= 1'b0;
      sol_q        <= 1'b0;
      sof_q        <= 1'b0;
      err_q        <= 1'b0;
    end else if (vif.cen_i) begin
      in_frame_q   <= in_frame_d;
      first_line_q <= first_line_d;
      line_idx_q   <= line_idx_d;
      sample_cnt_q <= sample_cnt_d;
      frame_err_q  <= frame_err_d;
      fvht_q       <= vif.fvht_i;
      vdat_q       <= vif.vdat_i;
      hcount_q     <= active ? cur_sample : '0;
      vcount_q     <= active ? line_idx_d : '0;
      active_q     <= active;
      sol_q        <= sol;
      sof_q        <= sol && (line_idx_d == '0);
      err_q        <= geo_err | (err_q & ~vif.err_clr_i);
    end
  end

  assign vif.fvht_o      = fvht_q;
  assign vif.vdat_o      = vdat_q;
  assign vif.hcount_o    = hcount_q;
  assign vif.vcount_o    = vcount_q;
  assign vif.active_o    = active_q;
  assign vif.chroma_cr_o = hcount_q[0];
  assign vif.sol_o       = sol_q;
  assign vif.sof_o       = sof_q;
  assign vif.locked_o    = (state_q == LOCKED);
  assign vif.err_o       = err_q;
endmodule

// File: tb/tb_video_raster_tracker.sv
// Scoreboard bench for video_raster_tracker on an 8x4 raster with 3 blank samples per line.
module tb_video_raster_tracker;
  import video_raster_tracker_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 12;
  localparam int HB = 3;

  typedef struct packed {
    logic [3:0]    fvht;
    logic [19:0]   vdat;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          act;
    logic          cr;
    logic          sol;
    logic          sof;
    logic          lk;
    logic          er;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  video_raster_tracker_if #(.CW(CW)) vif();

  video_raster_tracker #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CW       (CW),
    .LOCK_FRM (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          nsamp  = 0;
  bit          cen_toggle = 1'b0;
  logic [19:0] vd = 20'h00100;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s sample=%0d got=%0h exp=%0h", nm, nsamp, got, ex);
    end
  endtask

  exp_t me;
  always @(posedge clk) begin
    if (vif.cen_i === 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output sample=%0d got=output exp=none pending", nsamp);
      end else begin
        me = exp_q.pop_front();
        chk("fvht_o",      32'(vif.fvht_o),      32'(me.fvht));
        chk("vdat_o",      32'(vif.vdat_o),      32'(me.vdat));
        chk("hcount_o",    32'(vif.hcount_o),    32'(me.hc));
        chk("vcount_o",    32'(vif.vcount_o),    32'(me.vc));
        chk("active_o",    32'(vif.active_o),    32'(me.act));
        chk("chroma_cr_o", 32'(vif.chroma_cr_o), 32'(me.cr));
        chk("sol_o",       32'(vif.sol_o),       32'(me.sol));
        chk("sof_o",       32'(vif.sof_o),       32'(me.sof));
        chk("locked_o",    32'(vif.locked_o),    32'(me.lk));
        chk("err_o",       32'(vif.err_o),       32'(me.er));
        nsamp++;
      end
    end
  end

  // One enabled sample; in toggle mode it is followed by a disabled cycle of garbage.
  task automatic drive(input logic [3:0] f, input logic [19:0] d, input logic clr,
                       input logic r, input exp_t e);
    @(negedge clk);
    vif.cen_i     = 1'b1;
    vif.fvht_i    = f;
    vif.vdat_i    = d;
    vif.err_clr_i = clr;
    rst           = r;
    exp_q.push_back(e);
    if (cen_toggle) begin
      @(negedge clk);
      vif.cen_i     = 1'b0;
      vif.fvht_i    = 4'($urandom);
      vif.vdat_i    = 20'($urandom);
      vif.err_clr_i = 1'($urandom);
      rst           = 1'b0;
    end
  endtask

  // HB blank samples then n h=0 samples. eb/cb: expected err / err_clr per blank sample.
  task automatic line(input int n, input bit v, input int vc, input bit act,
                      input bit lk_b, input bit [2:0] eb, input bit [2:0] cb,
                      input bit lk_a, input bit er_a, input int rst_at);
    exp_t       e;
    logic [3:0] f;
    bit         dead;
    dead = 1'b0;
    for (int j = 0; j < HB; j++) begin
      f      = {1'b0, v, 1'b1, j[0]};
      e      = '0;
      e.fvht = f;
      e.vdat = vd;
      e.lk   = lk_b;
      e.er   = eb[j];
      drive(f, vd, cb[j], 1'b0, e);
      vd++;
    end
    for (int j = 0; j < n; j++) begin
      f      = {1'b0, v, 1'b0, j[0]};
      e      = '0;
      e.fvht = f;
      e.vdat = vd;
      if (rst_at >= 0 && j >= rst_at) dead = 1'b1;
      if (rst_at == j) begin
        e.fvht = '0;
        e.vdat = '0;
      end
      if (!dead) begin
        e.lk = lk_a;
        e.er = er_a;
        if (act) begin
          e.act = 1'b1;
          e.hc  = CW'(j);
          e.vc  = CW'(vc);
          e.cr  = j[0];
          e.sol = (j == 0);
          e.sof = (j == 0) && (vc == 0);
        end
      end
      drive(f, vd, 1'b0, rst_at == j, e);
      vd++;
    end
  endtask

  task automatic frame(input int nl, input bit lk);
    for (int l = 0; l < nl; l++)
      line(H, 1'b0, l, 1'b1, lk, 3'b000, 3'b000, lk, 1'b0, -1);
  endtask

  task automatic vblank(input bit lk_b, input bit [2:0] eb, input bit [2:0] cb,
                        input bit lk_a, input bit er_a);
    line(H, 1'b1, 0, 1'b0, lk_b, eb, cb, lk_a, er_a, -1);
  endtask

  initial begin
    vif.cen_i     = 1'b0;
    vif.fvht_i    = 4'b0110;
    vif.vdat_i    = '0;
    vif.err_clr_i = 1'b0;
    repeat (2) @(negedge clk);

    // reset with live input: outputs must read all zero
    drive(4'b0110, 20'hABCDE, 1'b0, 1'b1, '0);
    drive(4'b0110, 20'h12345, 1'b0, 1'b1, '0);

    // frames A, B clean -> lock declared at B's v_rise; C clean while locked
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    frame(V, 1'b0);
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    frame(V, 1'b0);
    vblank(1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
    frame(V, 1'b1);
    vblank(1'b1, 3'b000, 3'b000, 1'b1, 1'b0);

    // frame D: 7-sample line while locked, error cleared one sample later
    line(H, 1'b0, 0, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, -1);
    line(7, 1'b0, 1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, -1);
    line(H, 1'b0, 2, 1'b1, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, -1);
    line(H, 1'b0, 3, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

    // frame E with clock enable toggling every cycle
    cen_toggle = 1'b1;
    frame(V, 1'b0);
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cen_toggle = 1'b0;

    // frame F: reset at sample 3 of line 2, nothing active until the next frame
    line(H, 1'b0, 0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
    line(H, 1'b0, 1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
    line(H, 1'b0, 2, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3);
    line(H, 1'b0, 3, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    frame(V, 1'b0);
    vblank(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

    // frame H: 5 lines; clear coincides with the error and loses, then a lone clear
    frame(5, 1'b0);
    vblank(1'b0, 3'b111, 3'b001, 1'b0, 1'b1);
    vblank(1'b0, 3'b000, 3'b001, 1'b0, 1'b0);

    @(negedge clk);
    vif.cen_i = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
